// File: rtl/fact_sequencer.sv
// fact_sequencer
// Drives the memory-mapped factorial unit without CPU polling: writes n,
// pulses go for one cycle, polls status, fetches the result and reports it
// with a one-cycle done pulse. Owns the factorial A/WE/WD/RD port while busy.
// Optional feature macro: FACT_SEQ_TIMEOUT_EN (abort polling after
// TIMEOUT_CYCLES cycles in POLL/GAP; without it timeout is constant 0).
module fact_sequencer #(
    parameter int POLL_GAP       = 0,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  n,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        error,
    output logic        timeout,
    output logic [1:0]  fact_a,
    output logic        fact_we,
    output logic [3:0]  fact_wd,
    input  logic [31:0] fact_rd
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WR_N      = 3'd1,
        S_WR_GO     = 3'd2,
        S_WR_GO_CLR = 3'd3,
        S_POLL      = 3'd4,
        S_GAP       = 3'd5,
        S_RD_RES    = 3'd6,
        S_DONE      = 3'd7
    } state_t;

    // Gap counter holds "remaining GAP cycles minus one"; width covers POLL_GAP.
    localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = (POLL_GAP > 0) ? GAP_W'(POLL_GAP - 1) : '0;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_n;
    logic [3:0]        w_n_nxt;
    logic [GAP_W-1:0]  r_gap;
    logic [GAP_W-1:0]  w_gap_nxt;
    logic [31:0]       r_result;
    logic [31:0]       w_result_nxt;
    logic              r_error;
    logic              w_error_nxt;
    logic              r_timeout;
    logic              w_timeout_nxt;
    logic              r_busy;
    logic              r_done;
    logic [1:0]        r_fact_a;
    logic              r_fact_we;
    logic [3:0]        r_fact_wd;
    logic [1:0]        w_fact_a_nxt;
    logic              w_fact_we_nxt;
    logic [3:0]        w_fact_wd_nxt;
    logic              w_stat_done;
    logic              w_stat_err;
    logic              w_to_hit;

    assign w_stat_done = fact_rd[0];
    assign w_stat_err  = fact_rd[1];

`ifdef FACT_SEQ_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT_CYCLES > 0) ? TO_W'(TIMEOUT_CYCLES - 1) : '0;

    logic [TO_W-1:0] r_to_cnt;

    // Counter value = POLL/GAP cycles already spent; this cycle is the last allowed one.
    assign w_to_hit = (r_to_cnt >= TO_LAST);

    // Polling-time counter: cleared just before POLL entry, saturating in POLL/GAP
    always_ff @(posedge clock) begin
        if (reset) begin
            r_to_cnt <= '0;
        end else if (r_state == S_WR_GO_CLR) begin
            r_to_cnt <= '0;
        end else if (((r_state == S_POLL) || (r_state == S_GAP)) && (r_to_cnt != TO_MAX)) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end else begin
            r_to_cnt <= r_to_cnt;
        end
    end
`else
    assign w_to_hit = 1'b0;
`endif

    // Next-state and datapath update logic
    always_comb begin
        w_state_nxt   = r_state;
        w_n_nxt       = r_n;
        w_gap_nxt     = r_gap;
        w_result_nxt  = r_result;
        w_error_nxt   = r_error;
        w_timeout_nxt = r_timeout;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_n_nxt       = n;
                    w_result_nxt  = 32'd0;
                    w_error_nxt   = 1'b0;
                    w_timeout_nxt = 1'b0;
                    w_state_nxt   = S_WR_N;
                end else begin
                    w_state_nxt   = S_IDLE;
                end
            end
            S_WR_N:      w_state_nxt = S_WR_GO;
            S_WR_GO:     w_state_nxt = S_WR_GO_CLR;
            S_WR_GO_CLR: w_state_nxt = S_POLL;
            S_POLL: begin
                // Error outranks done; both outrank a timeout in the same cycle.
                if (w_stat_err) begin
                    w_error_nxt  = 1'b1;
                    w_result_nxt = 32'd0;
                    w_state_nxt  = S_DONE;
                end else if (w_stat_done) begin
                    w_state_nxt  = S_RD_RES;
                end else if (w_to_hit) begin
                    w_error_nxt   = 1'b1;
                    w_timeout_nxt = 1'b1;
                    w_result_nxt  = 32'd0;
                    w_state_nxt   = S_DONE;
                end else if (POLL_GAP == 0) begin
                    w_state_nxt  = S_POLL;
                end else begin
                    w_gap_nxt    = GAP_LOAD;
                    w_state_nxt  = S_GAP;
                end
            end
            S_GAP: begin
                if (w_to_hit) begin
                    w_error_nxt   = 1'b1;
                    w_timeout_nxt = 1'b1;
                    w_result_nxt  = 32'd0;
                    w_state_nxt   = S_DONE;
                end else if (r_gap == '0) begin
                    w_state_nxt   = S_POLL;
                end else begin
                    w_gap_nxt     = r_gap - 1'b1;
                end
            end
            S_RD_RES: begin
                w_result_nxt = fact_rd;
                w_state_nxt  = S_DONE;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Bus drive decoded from the upcoming state so the registered bus lines up with it
    always_comb begin
        w_fact_a_nxt  = 2'd0;
        w_fact_we_nxt = 1'b0;
        w_fact_wd_nxt = 4'd0;
        case (w_state_nxt)
            S_WR_N: begin
                w_fact_a_nxt  = 2'd0;
                w_fact_we_nxt = 1'b1;
                w_fact_wd_nxt = w_n_nxt;
            end
            S_WR_GO: begin
                w_fact_a_nxt  = 2'd1;
                w_fact_we_nxt = 1'b1;
                w_fact_wd_nxt = 4'd1;
            end
            S_WR_GO_CLR: begin
                w_fact_a_nxt  = 2'd1;
                w_fact_we_nxt = 1'b1;
                w_fact_wd_nxt = 4'd0;
            end
            S_POLL, S_GAP: w_fact_a_nxt = 2'd2;
            S_RD_RES:      w_fact_a_nxt = 2'd3;
            default: begin
                w_fact_a_nxt  = 2'd0;
                w_fact_we_nxt = 1'b0;
                w_fact_wd_nxt = 4'd0;
            end
        endcase
    end

    // State, datapath and output registers; reset aborts without a done pulse
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_n       <= 4'd0;
            r_gap     <= '0;
            r_result  <= 32'd0;
            r_error   <= 1'b0;
            r_timeout <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_fact_a  <= 2'd0;
            r_fact_we <= 1'b0;
            r_fact_wd <= 4'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_n       <= w_n_nxt;
            r_gap     <= w_gap_nxt;
            r_result  <= w_result_nxt;
            r_error   <= w_error_nxt;
            r_timeout <= w_timeout_nxt;
            r_busy    <= (w_state_nxt != S_IDLE);
            r_done    <= (w_state_nxt == S_DONE);
            r_fact_a  <= w_fact_a_nxt;
            r_fact_we <= w_fact_we_nxt;
            r_fact_wd <= w_fact_wd_nxt;
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign result  = r_result;
    assign error   = r_error;
    assign timeout = r_timeout;
    assign fact_a  = r_fact_a;
    assign fact_we = r_fact_we;
    assign fact_wd = r_fact_wd;

endmodule

// File: doc/fact_sequencer.md
Name: fact_sequencer

Overview:
Hardware sequencer that drives the memory-mapped factorial unit without CPU polling. On a start strobe it writes n, pulses go, polls status, fetches the result and returns it with a one-cycle done pulse. It sits between a local requester (CPU-side control register or test logic) and the factorial unit's A/WE/WD/RD port. It is the single owner of that port whenever busy is high.

Parameters:
POLL_GAP, 0, idle cycles inserted between consecutive status polls (0 = poll every cycle)
TIMEOUT_CYCLES, 1023, maximum cycles spent in POLL/GAP before abort (used only with FACT_SEQ_TIMEOUT_EN)

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request strobe, sampled only in IDLE
n  input  4  factorial operand, captured with start
busy  output  1  high in every state except IDLE
done  output  1  one-cycle completion pulse
result  output  32  n! on success, 0 on error; held until next accepted start
error  output  1  factorial unit reported error (or timeout); held like result
timeout  output  1  abort was due to timeout; held like result; constant 0 without macro
fact_a  output  2  factorial register address: 0=n, 1=go, 2=status, 3=result
fact_we  output  1  factorial write enable
fact_wd  output  4  factorial write data
fact_rd  input  32  factorial read data, combinational from fact_a; status: bit0=done, bit1=error

Behaviour:
- Reset: state=IDLE; busy=0, done=0, result=0, error=0, timeout=0, fact_a=0, fact_we=0, fact_wd=0; gap/timeout counters=0. Reset mid-operation aborts immediately, no done pulse.
- IDLE: bus outputs all 0. start=1 -> capture n; clear result/error/timeout; next state WR_N.
- WR_N: fact_a=0, fact_we=1, fact_wd=n_reg -> WR_GO.
- WR_GO: fact_a=1, fact_we=1, fact_wd=4'd1 -> WR_GO_CLR.
- WR_GO_CLR: fact_a=1, fact_we=1, fact_wd=4'd0 -> POLL. The go write is therefore a one-cycle pulse.
- POLL: fact_a=2, fact_we=0. Sample fact_rd in the same cycle:
  - bit1=1 -> error=1, result=0 -> DONE. Error takes priority over done.
  - else bit0=1 -> RD_RES.
  - else POLL_GAP=0 -> stay in POLL.
  - else load the gap counter -> GAP.
- GAP: fact_a=2, fact_we=0. Counts POLL_GAP cycles, then -> POLL.
- RD_RES: fact_a=3, fact_we=0. result<=fact_rd -> DONE.
- DONE: done=1 for exactly one cycle, busy=1 -> IDLE. busy falls in the cycle after done.
- Minimum latency, start accepted to done: WR_N, WR_GO, WR_GO_CLR, POLL, RD_RES, DONE = 6 cycles when status shows done on the first poll.
- start while busy (including DONE) is ignored, not queued.
- fact_we is asserted only in WR_N/WR_GO/WR_GO_CLR and never while fact_a is 2 or 3.
- Counters saturate and never wrap. The gap counter width covers POLL_GAP; the timeout counter width is clog2(TIMEOUT_CYCLES+1).

Optional Feature:
FACT_SEQ_TIMEOUT_EN
- Defined: a cycle counter clears on entry to POLL from WR_GO_CLR and increments every cycle in POLL/GAP. If it reaches TIMEOUT_CYCLES before status done/error -> error=1, timeout=1, result=0 -> DONE. Done or error seen in the same cycle as the limit takes priority over timeout.
- Undefined: no counter; POLL/GAP loop until the factorial unit reports status; timeout tied 0; TIMEOUT_CYCLES ignored.

Test Plan:
- POLL_GAP=0, start with n=5 -> bus sequence (a,we,wd) = (0,1,5),(1,1,1),(1,1,0), then polls at a=2. done pulses once; result=32'd120, error=0; busy low the cycle after done.
- n=0 then n=1 back-to-back, each start issued after the prior done -> result=1 both times. The second start, pulsed during DONE, is ignored and must be re-issued from IDLE.
- n=13 -> factorial status bit1 set -> done pulse, error=1, result=0, no RD_RES cycle (fact_a never 3).
- POLL_GAP=3 with status done after 10 cycles -> polls at a=2 are spaced by 3 GAP cycles; final result correct; no writes during the poll phase.
- reset asserted for 1 cycle while in POLL -> next cycle IDLE, all outputs 0, no done pulse; a new start n=4 yields result=24.
- FACT_SEQ_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, status stub never done -> done exactly 16 cycles after POLL entry; error=1, timeout=1, result=0.
